// File: rtl/tl_pkg.sv
// Shared definitions for the intersection controller.
//   - Signal head encodings (one-hot green / yellow / red)
//   - Walk indicator levels
//   - Six-state phase enum, its fixed cyclic successor and head decoders
package tl_pkg;

  localparam logic [2:0] GREEN_OUT  = 3'd1;
  localparam logic [2:0] YELLOW_OUT = 3'd2;
  localparam logic [2:0] RED_OUT    = 3'd4;

  localparam logic WALK = 1'b1;
  localparam logic STOP = 1'b0;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } tl_state_e;

  // Unused encodings fall back to all-red so the next tick restarts at NS.
  function automatic tl_state_e next_state(input tl_state_e s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_A;
      ALLRED_A:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED_B;
      ALLRED_B:  return NS_GREEN;
      default:   return ALLRED_B;
    endcase
  endfunction

  // Each head is red unless the state explicitly names it, so both heads
  // can never show green together.
  function automatic logic [2:0] ns_head(input tl_state_e s);
    case (s)
      NS_GREEN:  return GREEN_OUT;
      NS_YELLOW: return YELLOW_OUT;
      default:   return RED_OUT;
    endcase
  endfunction

  function automatic logic [2:0] ew_head(input tl_state_e s);
    case (s)
      EW_GREEN:  return GREEN_OUT;
      EW_YELLOW: return YELLOW_OUT;
      default:   return RED_OUT;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 4-bit loadable down-counter used as the shared phase timer.
//   clk, rst      : clock, asynchronous active-high reset (count -> RST_VAL)
//   tick          : time-base strobe; decrements while count is non-zero
//   load/load_val : synchronous load, takes priority over decrement
//   count         : current value (ticks remaining minus one)
//   done          : tick seen while count is zero (phase is ending)
module phase_timer #(
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       done
);

  logic [3:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign count = count_q;
  assign done  = tick && (count_q == 4'd0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-direction intersection sequencer.
// Cycles NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW ->
// ALLRED_B, advancing only on tick, and latches pedestrian requests that
// are granted as a walk for the whole next green of that direction.
//   clk, rst               : clock, asynchronous active-high reset
//   tick                   : one-clock time-base strobe
//   ped_req_ns/ped_req_ew  : crosswalk buttons (any pulse width)
//   ns_light/ew_light      : one-hot heads (1 green, 2 yellow, 4 red)
//   ns_walk/ew_walk        : walk indicators
//   phase_cnt              : ticks remaining in phase minus one
//   ped_pend               : latched requests, [1] EW, [0] NS
// Optional build macro TL_PED_EXTEND_EN: a green that grants a walk runs
// for GREEN_T+PED_EXT ticks instead of GREEN_T.
module intersection_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_EXT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ns_walk,
  output logic       ew_walk,
  output logic [3:0] phase_cnt,
  output logic [1:0] ped_pend
);

  // Reject illegal timing parameters at elaboration.
  if (GREEN_T < 1 || GREEN_T > 15 || YELLOW_T < 1 || YELLOW_T > 15 ||
      ALLRED_T < 1 || ALLRED_T > 15 || PED_EXT < 0 ||
      GREEN_T + PED_EXT > 15) begin : g_bad_timing
    $error("intersection_ctrl: timing parameter out of range");
  end

  localparam logic [3:0] GREEN_LD  = 4'(GREEN_T - 1);
  localparam logic [3:0] YELLOW_LD = 4'(YELLOW_T - 1);
  localparam logic [3:0] ALLRED_LD = 4'(ALLRED_T - 1);
`ifdef TL_PED_EXTEND_EN
  localparam logic [3:0] GREEN_EXT_LD = 4'(GREEN_T + PED_EXT - 1);
`endif

  tl_state_e  state_q, state_d;
  logic [2:0] ns_light_q, ns_light_d;
  logic [2:0] ew_light_q, ew_light_d;
  logic       ns_walk_q, ns_walk_d;
  logic       ew_walk_q, ew_walk_d;
  logic [1:0] pend_q, pend_d;

  logic       done;
  logic [3:0] load_val;
  logic       grant_ns, grant_ew;

  phase_timer #(
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (done),
    .load_val (load_val),
    .count    (phase_cnt),
    .done     (done)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    pend_d    = pend_q | {ped_req_ew, ped_req_ns};
    ns_walk_d = ns_walk_q;
    ew_walk_d = ew_walk_q;
    grant_ns  = 1'b0;
    grant_ew  = 1'b0;
    load_val  = ALLRED_LD;

    if (done) begin
      state_d = next_state(state_q);

      // Grant on green entry covers a request sampled on the entry edge too.
      grant_ns = (state_d == NS_GREEN) && (pend_q[0] || ped_req_ns);
      grant_ew = (state_d == EW_GREEN) && (pend_q[1] || ped_req_ew);

      // Leaving a green always drops its walk.
      if (state_q == NS_GREEN) ns_walk_d = STOP;
      if (state_q == EW_GREEN) ew_walk_d = STOP;

      if (grant_ns) begin
        ns_walk_d = WALK;
        pend_d[0] = 1'b0;
      end
      if (grant_ew) begin
        ew_walk_d = WALK;
        pend_d[1] = 1'b0;
      end
    end

    case (state_d)
      NS_GREEN, EW_GREEN: begin
        load_val = GREEN_LD;
`ifdef TL_PED_EXTEND_EN
        if (grant_ns || grant_ew) load_val = GREEN_EXT_LD;
`endif
      end
      NS_YELLOW, EW_YELLOW: load_val = YELLOW_LD;
      default:              load_val = ALLRED_LD;
    endcase

    ns_light_d = ns_head(state_d);
    ew_light_d = ew_head(state_d);
  end

  // Reset parks in ALLRED_B so the first tick after release opens NS green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALLRED_B;
      ns_light_q <= RED_OUT;
      ew_light_q <= RED_OUT;
      ns_walk_q  <= STOP;
      ew_walk_q  <= STOP;
      pend_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      ns_walk_q  <= ns_walk_d;
      ew_walk_q  <= ew_walk_d;
      pend_q     <= pend_d;
    end
  end

  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign ns_walk  = ns_walk_q;
  assign ew_walk  = ew_walk_q;
  assign ped_pend = pend_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with default timing
// (green 5, yellow 2, all-red 1). Outputs are sampled on the falling edge.
module tb_intersection_ctrl;

`ifdef TL_PED_EXTEND_EN
  localparam int EXT = 3;
`else
  localparam int EXT = 0;
`endif
  localparam int GRANT_GREEN = 5 + EXT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic       ns_walk, ew_walk;
  logic [3:0] phase_cnt;
  logic [1:0] ped_pend;

  int n_total = 0;
  int n_bad   = 0;

  // Expected schedule without requests: {ns head, ew head, length in ticks}.
  int ph_ns  [6] = '{1, 2, 4, 4, 4, 4};
  int ph_ew  [6] = '{4, 4, 4, 1, 2, 4};
  int ph_len [6] = '{5, 2, 1, 5, 2, 1};

  intersection_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ns_walk    (ns_walk),
    .ew_walk    (ew_walk),
    .phase_cnt  (phase_cnt),
    .ped_pend   (ped_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse reset and release on a falling edge with tick high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    @(negedge clk);
    rst = 1'b0; tick = 1'b1;
  endtask

  // Walk the no-request schedule with one tick every 'scale' clocks.
  task automatic run_cycle(input int scale, input int reps);
    for (int r = 0; r < reps; r++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < ph_len[p]; k++)
          for (int s = 0; s < scale; s++) begin
            @(negedge clk);
            check("cyc_ns_light", ns_light, 8'(ph_ns[p]));
            check("cyc_ew_light", ew_light, 8'(ph_ew[p]));
            check("cyc_phase_cnt", phase_cnt, 8'(ph_len[p] - 1 - k));
            check("cyc_walks", {ns_walk, ew_walk}, 8'd0);
            tick = (s == scale - 1);
          end
  endtask

  initial begin
    // Power-on reset state.
    #12;
    check("rst_ns_light", ns_light, 8'd4);
    check("rst_ew_light", ew_light, 8'd4);
    check("rst_walks", {ns_walk, ew_walk}, 8'd0);
    check("rst_pend", ped_pend, 8'd0);
    check("rst_phase_cnt", phase_cnt, 8'd0);

    // Full cycle twice with tick tied high.
    @(negedge clk);
    rst = 1'b0; tick = 1'b1;
    run_cycle(1, 2);

    // Sparse tick: every phase scaled by four, counter holds between ticks.
    do_reset();
    run_cycle(4, 1);

    // EW request during NS green, granted on EW green entry.
    do_reset();
    @(negedge clk);                         // N1: NS green
    check("ew_req_ns_green", ns_light, 8'd1);
    ped_req_ew = 1'b1;
    @(negedge clk);                         // N2
    ped_req_ew = 1'b0;
    check("ew_req_pend", ped_pend, 8'b10);
    check("ew_req_no_walk", ew_walk, 8'd0);
    repeat (7) @(negedge clk);              // N9: EW green entry
    check("ew_grant_light", ew_light, 8'd1);
    check("ew_grant_walk", ew_walk, 8'd1);
    check("ew_grant_pend", ped_pend, 8'd0);
    check("ew_grant_ns_walk", ns_walk, 8'd0);
    repeat (GRANT_GREEN - 1) @(negedge clk); // last EW green clock
    check("ew_walk_held", ew_walk, 8'd1);
    check("ew_green_held", ew_light, 8'd1);
    @(negedge clk);                         // EW yellow entry
    check("ew_yellow_light", ew_light, 8'd2);
    check("ew_walk_dropped", ew_walk, 8'd0);

    // Asynchronous reset in the middle of EW green with a request pending.
    do_reset();
    @(negedge clk);                         // N1: NS green, after entry
    ped_req_ns = 1'b1;
    @(negedge clk);                         // N2
    ped_req_ns = 1'b0;
    check("late_req_pend", ped_pend, 8'b01);
    check("late_req_no_walk", ns_walk, 8'd0);
    repeat (8) @(negedge clk);              // N10: EW green
    check("mid_ew_light", ew_light, 8'd1);
    check("mid_ew_pend", ped_pend, 8'b01);
    #1 rst = 1'b1;
    #1;
    check("arst_ns_light", ns_light, 8'd4);
    check("arst_ew_light", ew_light, 8'd4);
    check("arst_walks", {ns_walk, ew_walk}, 8'd0);
    check("arst_pend", ped_pend, 8'd0);
    check("arst_phase_cnt", phase_cnt, 8'd0);

    // NS request coincident with NS green entry.
    @(negedge clk);
    rst = 1'b0; tick = 1'b1; ped_req_ns = 1'b1;
    @(negedge clk);                         // N1: NS green entry
    ped_req_ns = 1'b0;
    check("ns_grant_light", ns_light, 8'd1);
    check("ns_grant_walk", ns_walk, 8'd1);
    check("ns_grant_pend", ped_pend, 8'd0);
    check("ns_grant_ew_light", ew_light, 8'd4);
    repeat (GRANT_GREEN - 1) @(negedge clk);
    check("ns_grant_last_green", ns_light, 8'd1);
    check("ns_grant_walk_held", ns_walk, 8'd1);
    @(negedge clk);
    check("ns_grant_yellow", ns_light, 8'd2);
    check("ns_grant_walk_drop", ns_walk, 8'd0);
    // Next NS green without a request lasts exactly five ticks.
    repeat (11) @(negedge clk);             // next NS green entry
    check("ns_next_entry", ns_light, 8'd1);
    check("ns_next_no_walk", ns_walk, 8'd0);
    repeat (4) @(negedge clk);
    check("ns_next_last_green", ns_light, 8'd1);
    @(negedge clk);
    check("ns_next_yellow", ns_light, 8'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
